alu_result_stage: RTL

// Execute-stage result buffer directly downstream of the ALU.

---
 rtl/alu_result_stage.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// Two-entry result FIFO behind the ALU: resolves branch compares at push, keeps sticky overflow and taken count.
// Latency: an entry pushed at edge N is at the head from edge N onward; there is no input-to-output bypass.
// Backpressure: in_ready = (count != 2), taken from registered state only and independent of out_ready.
module alu_result_stage #(
    parameter int WIDTH = 16,
    parameter int TAGW  = 5,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] y,
    input  logic             zero,
    input  logic             carry_out,
    input  logic             overflow,
    input  logic             in_br_en,
    input  logic [2:0]       in_br_type,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_taken,
    output logic [TAGW-1:0]  out_tag,
    output logic [1:0]       count,
    input  logic             sticky_clr,
    output logic             sticky_ovf,
    output logic [CNTW-1:0]  taken_cnt
);

    logic [WIDTH-1:0] y_q     [2];
    logic             zero_q  [2];
    logic             taken_q [2];
    logic [TAGW-1:0]  tag_q   [2];

    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;
    logic            sticky_q, sticky_d;
    logic [CNTW-1:0] taken_cnt_q, taken_cnt_d;

    logic push, pop;
    logic lt, ltu, cond, taken_in;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Flags come from a SUB: signed less-than is N^V, unsigned less-than is the borrow.
    assign lt  = y[WIDTH-1] ^ overflow;
    assign ltu = carry_out;

    always_comb begin
        cond = 1'b0;
        case (in_br_type)
            3'b000:  cond = zero;
            3'b001:  cond = ~zero;
            3'b100:  cond = lt;
            3'b101:  cond = ~lt;
            3'b110:  cond = ltu;
            3'b111:  cond = ~ltu;
            default: cond = 1'b0;
        endcase
    end

    assign taken_in = in_br_en & cond;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        sticky_d    = sticky_q;
        taken_cnt_d = taken_cnt_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // A new overflow outranks a same-cycle clear.
        if (push && overflow)  sticky_d = 1'b1;
        else if (sticky_clr)   sticky_d = 1'b0;
        if (pop && taken_q[rd_ptr_q] && (taken_cnt_q != {CNTW{1'b1}}))
            taken_cnt_d = taken_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            sticky_q    <= 1'b0;
            taken_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sticky_q    <= sticky_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    // Entry payload needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            y_q[wr_ptr_q]     <= y;
            zero_q[wr_ptr_q]  <= zero;
            taken_q[wr_ptr_q] <= taken_in;
            tag_q[wr_ptr_q]   <= in_tag;
        end
    end

    assign out_result = out_valid ? y_q[rd_ptr_q]     : '0;
    assign out_zero   = out_valid ? zero_q[rd_ptr_q]  : 1'b0;
    assign out_taken  = out_valid ? taken_q[rd_ptr_q] : 1'b0;
    assign out_tag    = out_valid ? tag_q[rd_ptr_q]   : '0;
    assign count      = count_q;
    assign sticky_ovf = sticky_q;
    assign taken_cnt  = taken_cnt_q;

endmodule
